// File: rtl/decoder_seq_if.sv
// decoder_seq_if -- bundle of decode-request and scan-control signals for decoder_seq.
//   Parameter N : binary select width; the decoded output is 2^N bits wide.
//   master : drives en, in_valid, in, scan_start, scan_abort;
//            observes in_ready, out, out_valid, busy, scan_done.
//   slave  : the decoder side (directions reversed).
interface decoder_seq_if #(
  parameter int N = 2
);
  logic               en;
  logic               in_valid;
  logic [N-1:0]       in;
  logic               in_ready;
  logic               scan_start;
  logic               scan_abort;
  logic [(1<<N)-1:0]  out;
  logic               out_valid;
  logic               busy;
  logic               scan_done;

  modport master (
    output en, in_valid, in, scan_start, scan_abort,
    input  in_ready, out, out_valid, busy, scan_done
  );

  modport slave (
    input  en, in_valid, in, scan_start, scan_abort,
    output in_ready, out, out_valid, busy, scan_done
  );
endinterface

// File: rtl/decoder_seq.sv
// decoder_seq -- registered N-to-2^N one-hot decoder with a walking-one scan mode.
//   Parameters : N (select width, default 2), DWELL (cycles each scan code is held, 1..255).
//   clk        : single clock, rising edge.
//   rst_n      : asynchronous active-low reset.
//   bus        : decoder_seq_if.slave
//                  en/in_valid/in -> decode request, in_ready accepts it (IDLE only)
//                  out/out_valid  -> registered decode result, one-cycle valid pulse
//                  scan_start/scan_abort -> control of the walking-one scan
//                  busy           -> high while scanning
//                  scan_done      -> one-cycle pulse on natural scan completion
module decoder_seq #(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  decoder_seq_if.slave   bus
);

  localparam int W  = 1 << N;
  localparam int DW = $clog2(DWELL + 1);

  localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   idx_reg, idx_next;
  logic [DW-1:0]  dwell_reg, dwell_next;
  logic [W-1:0]   out_reg, out_next;
  logic           out_valid_reg, out_valid_next;
  logic           scan_done_reg, scan_done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      dwell_reg     <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      scan_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      dwell_reg     <= dwell_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      scan_done_reg <= scan_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    dwell_next     = dwell_reg;
    out_next       = out_reg;
    out_valid_next = 1'b0;
    scan_done_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // scan_start outranks a simultaneous request; the request is dropped.
        if (bus.scan_start) begin
          state_next = SCAN;
          idx_next   = '0;
          dwell_next = '0;
          out_next   = W'(1);
        end else if (bus.in_valid) begin
          out_next       = bus.en ? (W'(1) << bus.in) : '0;
          out_valid_next = 1'b1;
        end
      end

      SCAN: begin
        // Abort is checked first so it also wins over the final dwell cycle.
        if (bus.scan_abort) begin
          state_next = IDLE;
          idx_next   = '0;
          dwell_next = '0;
          out_next   = '0;
        end else if (dwell_reg == DWELL_LAST) begin
          dwell_next = '0;
          if (idx_reg == IDX_LAST) begin
            state_next     = IDLE;
            idx_next       = '0;
            out_next       = '0;
            scan_done_next = 1'b1;
          end else begin
            idx_next = idx_reg + N'(1);
            out_next = W'(1) << (idx_reg + N'(1));
          end
        end else begin
          dwell_next = dwell_reg + DW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg == SCAN);
  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.scan_done = scan_done_reg;

endmodule
